spi_ram_burst: RTL

- Parametrised successor to the SPI slave's command-decoded single-port RAM. It sits behind the SPI slave shifter and takes command/data words on rx_valid.
- Generalises data width, address width and depth.
- Adds auto-incrementing burst reads/writes with wrap at MEM_DEPTH, address-valid tracking, and an error pulse for illegal accesses.
- Read data returns to the SPI slave on dout/tx_valid.

---
 rtl/spi_ram_burst.sv | 135 +++++++++++++
 1 files changed

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - command-decoded single-port RAM with auto-increment bursts
//
// Purpose:
//   Sits behind an SPI slave shifter. Each din word on rx_valid carries a
//   2-bit opcode plus payload: set write address, write data, set read
//   address, or read data. Addresses auto-increment (with explicit wrap at
//   MEM_DEPTH-1) when AUTO_INC is set. Illegal accesses raise a one-cycle err.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   din      - {opcode[1:0], payload[DATA_W-1:0]}
//   rx_valid - din qualifier, one command per cycle
//   dout     - registered read data (holds between reads)
//   tx_valid - one-cycle strobe per successful READ
//   err      - one-cycle pulse after an illegal command
module spi_ram_burst #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int AUTO_INC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              err
);

   localparam logic [1:0] OP_SET_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE     = 2'b01;
   localparam logic [1:0] OP_SET_RADDR = 2'b10;
   localparam logic [1:0] OP_READ      = 2'b11;

   // One extra bit so MEM_DEPTH == 2**ADDR_W is representable in the range check.
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(MEM_DEPTH - 1);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_wr_vld;
   logic              r_rd_vld;
   logic [DATA_W-1:0] r_dout;
   logic              r_tx_valid;
   logic              r_err;

   logic [1:0]        w_op;
   logic [DATA_W-1:0] w_payload;
   logic [ADDR_W-1:0] w_addr;
   logic              w_addr_ok;
   logic [ADDR_W-1:0] w_wr_next;
   logic [ADDR_W-1:0] w_rd_next;
   logic              w_do_write;
   logic              w_do_read;

   always_comb begin
      w_op       = din[DATA_W+1:DATA_W];
      w_payload  = din[DATA_W-1:0];
      w_addr     = w_payload[ADDR_W-1:0];
      w_addr_ok  = ({1'b0, w_addr} < LP_DEPTH);
      // Explicit wrap so non-power-of-2 depths never index past the array.
      w_wr_next  = (r_wr_addr == LP_LAST) ? '0 : r_wr_addr + 1'b1;
      w_rd_next  = (r_rd_addr == LP_LAST) ? '0 : r_rd_addr + 1'b1;
      w_do_write = rst_n && rx_valid && (w_op == OP_WRITE) && r_wr_vld;
      w_do_read  = rx_valid && (w_op == OP_READ) && r_rd_vld;
   end

   // Storage has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_do_write) begin
         r_mem[r_wr_addr] <= w_payload;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_addr  <= '0;
         r_rd_addr  <= '0;
         r_wr_vld   <= 1'b0;
         r_rd_vld   <= 1'b0;
         r_dout     <= '0;
         r_tx_valid <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_tx_valid <= 1'b0;
         r_err      <= 1'b0;
         if (rx_valid) begin
            unique case (w_op)
               OP_SET_WADDR: begin
                  if (w_addr_ok) begin
                     r_wr_addr <= w_addr;
                     r_wr_vld  <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               OP_WRITE: begin
                  if (r_wr_vld) begin
                     if (AUTO_INC != 0) r_wr_addr <= w_wr_next;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               OP_SET_RADDR: begin
                  if (w_addr_ok) begin
                     r_rd_addr <= w_addr;
                     r_rd_vld  <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               OP_READ: begin
                  if (w_do_read) begin
                     // A WRITE on the previous edge is already in r_mem, so no stale data.
                     r_dout     <= r_mem[r_rd_addr];
                     r_tx_valid <= 1'b1;
                     if (AUTO_INC != 0) r_rd_addr <= w_rd_next;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign dout     = r_dout;
   assign tx_valid = r_tx_valid;
   assign err      = r_err;

endmodule
